// File: rtl/vedic_divider_16x8_seq.sv
// Sequential radix-2 restoring divider, N_W-bit dividend / D_W-bit divisor, one quotient bit per clock.
// Define VEDIC_DIV_SIGNED_EN for two's-complement operands (magnitude core plus one sign fix-up cycle).
module vedic_divider_16x8_seq #(
    parameter int N_W = 16,
    parameter int D_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N_W-1:0] dividend,
    input  logic [D_W-1:0] divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N_W-1:0] quotient,
    output logic [D_W-1:0] remainder,
    output logic           div_by_zero
);
    localparam int CW = (N_W > 1) ? $clog2(N_W) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    typedef struct packed {
        logic [N_W-1:0] mag_n;
        logic [D_W-1:0] mag_d;
        logic           neg_n;
        logic           neg_d;
    } req_t;

    state_t         state;
    logic [D_W-1:0] rem_r;
    logic [N_W-1:0] quo_r;
    logic [D_W-1:0] div_r;
    logic [CW-1:0]  cnt;
    logic           iter_done;
    logic           dz_r;
    req_t           req;

`ifdef VEDIC_DIV_SIGNED_EN
    logic q_neg;
    logic r_neg;

    assign req.neg_n = dividend[N_W-1];
    assign req.neg_d = divisor[D_W-1];
    assign req.mag_n = req.neg_n ? -dividend : dividend;
    assign req.mag_d = req.neg_d ? -divisor  : divisor;
`else
    assign req.neg_n = 1'b0;
    assign req.neg_d = 1'b0;
    assign req.mag_n = dividend;
    assign req.mag_d = divisor;
`endif

    // Working partial remainder is D_W+1 bits: shifted value can reach 2*divisor-1.
    logic [D_W:0]   shifted;
    logic           fits;
    logic [D_W-1:0] diff;

    assign shifted = {rem_r, quo_r[N_W-1]};
    assign fits    = (shifted >= {1'b0, div_r});
    assign diff    = shifted[D_W-1:0] - div_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            rem_r       <= '0;
            quo_r       <= '0;
            div_r       <= '0;
            cnt         <= '0;
            iter_done   <= 1'b0;
            dz_r        <= 1'b0;
`ifdef VEDIC_DIV_SIGNED_EN
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready  <= 1'b0;
                        rem_r     <= '0;
                        cnt       <= CW'(N_W - 1);
                        iter_done <= 1'b0;
                        dz_r      <= (divisor == '0);
                        div_r     <= req.mag_d;
                        // Raw dividend kept for divide-by-zero so its low byte becomes the remainder.
                        quo_r     <= (divisor == '0) ? dividend : req.mag_n;
`ifdef VEDIC_DIV_SIGNED_EN
                        q_neg     <= req.neg_n ^ req.neg_d;
                        r_neg     <= req.neg_n;
`endif
                        state     <= CALC;
                    end
                end
                CALC: begin
                    if (dz_r) begin
                        quotient    <= '1;
                        remainder   <= quo_r[D_W-1:0];
                        div_by_zero <= 1'b1;
                        out_valid   <= 1'b1;
                        state       <= DONE;
                    end else if (!iter_done) begin
                        rem_r <= fits ? diff : shifted[D_W-1:0];
                        quo_r <= {quo_r[N_W-2:0], fits};
                        if (cnt == '0) iter_done <= 1'b1;
                        else           cnt       <= cnt - 1'b1;
                    end else begin
`ifdef VEDIC_DIV_SIGNED_EN
                        state <= FIX;
`else
                        quotient    <= quo_r;
                        remainder   <= rem_r;
                        div_by_zero <= 1'b0;
                        out_valid   <= 1'b1;
                        state       <= DONE;
`endif
                    end
                end
`ifdef VEDIC_DIV_SIGNED_EN
                FIX: begin
                    // Truncate toward zero; remainder follows dividend sign.
                    quotient    <= q_neg ? -quo_r : quo_r;
                    remainder   <= r_neg ? -rem_r : rem_r;
                    div_by_zero <= 1'b0;
                    out_valid   <= 1'b1;
                    state       <= DONE;
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule
